serial_frame_receiver: RTL

- Downstream consumer of the single-bit D flip-flop register stage.
- Takes the registered serial line (idle high) and detects a start bit.
- Samples DATA_W data bits LSB-first at mid-bit, then checks the stop bit.
- Presents each good byte to the next stage through a dav/rfd handshake and flags framing and overrun errors.

---
 rtl/serial_frame_receiver.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start-bit detect, mid-bit sampling of an LSB-first word,
// stop-bit check, and a dav/rfd handoff with framing and overrun reporting.
`timescale 1ns/1ps
module serial_frame_receiver #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_in,
  input  logic              rfd,
  output logic [DATA_W-1:0] byte_out,
  output logic              dav,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IdxW = $clog2(DATA_W + 1);

  localparam logic [CntW-1:0] CntHalf = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [IdxW-1:0]    r_idx;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_byte;
  logic               r_dav;
  logic               r_frame_err;
  logic               r_overrun;

  logic               w_cnt_zero;
  logic [DATA_W-1:0]  w_msb;
  logic [DATA_W-1:0]  w_shift_next;

  assign w_cnt_zero   = (r_cnt == '0);
  // LSB-first frame: each new bit enters at the MSB and older bits move down.
  assign w_msb        = DATA_W'(d_in) << (DATA_W - 1);
  assign w_shift_next = (r_shift >> 1) | w_msb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_dav       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_dav && rfd) begin
        r_dav <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (!d_in) begin
            r_state <= StStart;
            r_cnt   <= CntHalf;
          end
        end

        StStart: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!d_in) begin
            r_state <= StData;
            r_cnt   <= CntFull;
            r_idx   <= '0;
          end else begin
            r_state <= StIdle;
          end
        end

        StData: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= w_shift_next;
            r_cnt   <= CntFull;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == IdxLast) begin
              r_state <= StStop;
            end
          end
        end

        StStop: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (d_in) begin
            // A same-cycle ack frees the holding slot, so the new byte overrides the clear.
            if (!r_dav || rfd) begin
              r_byte <= r_shift;
              r_dav  <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= StIdle;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= StWaitHigh;
          end
        end

        StWaitHigh: begin
          if (d_in) begin
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign byte_out  = r_byte;
  assign dav       = r_dav;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
